// File: rtl/spell_recorder.sv
// Records one-hot move button presses into an external LIFO stack and replays
// them last-first, presenting each move for HOLD_CYCLES clocks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | wait for synchronised reset release, pulse stk_clr once
// IDLE     | accept clear / replay_start / record_en
// RECORD   | push each single-button rising edge, flag overflow when full
// POP_REQ  | issue stk_pop for the top move
// POP_WAIT | capture popped move into replay_code
// SHOW     | hold replay_valid for HOLD_CYCLES cycles
// DONE     | one-cycle replay_done pulse
module spell_recorder #(
    parameter int DATA_WIDTH  = 4,
    parameter int MAX_DEPTH   = 64,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        btn,
    input  logic                         record_en,
    input  logic                         replay_start,
    input  logic                         clear,
    output logic [DATA_WIDTH-1:0]        stk_d,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic                         stk_clr,
    input  logic [DATA_WIDTH-1:0]        stk_q,
    output logic [DATA_WIDTH-1:0]        replay_code,
    output logic                         replay_valid,
    output logic                         replay_done,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(MAX_DEPTH):0]   depth
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH) + 1;
    localparam int HOLD_W  = 26;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RECORD,
        S_POP_REQ,
        S_POP_WAIT,
        S_SHOW,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          rst_sync;
    logic                run;
    logic [DATA_WIDTH-1:0] btn_prev;
    logic [DATA_WIDTH-1:0] btn_rise;
    logic                move_evt;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                depth_inc;
    logic                depth_dec;
    logic                depth_zero;
    logic                ovf_set;
    logic                ovf_clr;
    logic                load_code;
    logic                hold_load;

    // Assertion is immediate; release only takes effect two edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
        end else if (!run) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_prev <= '0;
        end else begin
            btn_prev <= btn;
        end
    end

    assign btn_rise = btn & ~btn_prev;
    assign move_evt = $onehot(btn_rise);

    always_comb begin
        state_nxt  = state;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clr    = 1'b0;
        depth_inc  = 1'b0;
        depth_dec  = 1'b0;
        depth_zero = 1'b0;
        ovf_set    = 1'b0;
        ovf_clr    = 1'b0;
        load_code  = 1'b0;
        hold_load  = 1'b0;

        case (state)
            S_INIT: begin
                if (run) begin
                    stk_clr    = 1'b1;
                    depth_zero = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clear) begin
                    stk_clr    = 1'b1;
                    depth_zero = 1'b1;
                    ovf_clr    = 1'b1;
                end else if (replay_start) begin
                    state_nxt = (depth != '0) ? S_POP_REQ : S_DONE;
                end else if (record_en) begin
                    state_nxt = S_RECORD;
                end
            end
            S_RECORD: begin
                if (move_evt) begin
                    if (depth < DEPTH_MAX) begin
                        stk_push  = 1'b1;
                        depth_inc = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                if (!record_en) begin
                    state_nxt = S_IDLE;
                end
            end
            S_POP_REQ: begin
                stk_pop   = 1'b1;
                depth_dec = (depth != '0);
                state_nxt = S_POP_WAIT;
            end
            S_POP_WAIT: begin
                load_code = 1'b1;
                hold_load = 1'b1;
                state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (hold_cnt == '0) begin
                    state_nxt = (depth != '0) ? S_POP_REQ : S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    assign stk_d        = stk_push ? btn : '0;
    assign replay_valid = (state == S_SHOW);
    assign replay_done  = (state == S_DONE);
    assign busy         = run && (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
        end else if (depth_zero) begin
            depth <= '0;
        end else if (depth_inc) begin
            depth <= depth + DEPTH_W'(1);
        end else if (depth_dec) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            replay_code <= '0;
        end else if (load_code) begin
            replay_code <= stk_q;
        end
    end

    // Loaded to HOLD_CYCLES-1 so SHOW lasts exactly HOLD_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (hold_load) begin
            hold_cnt <= HOLD_LOAD;
        end else if (state == S_SHOW && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

endmodule

// File: tb/tb_spell_recorder.sv
// Bench for spell_recorder: LIFO stack model plus a cycle-level reference
// derived from the replay timing arithmetic, with directed move sequences.
module tb_spell_recorder;

    localparam int DW = 4;
    localparam int MD = 4;
    localparam int HC = 4;
    localparam int P  = HC + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] btn = '0;
    logic          record_en = 1'b0;
    logic          replay_start = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] stk_d;
    logic          stk_push, stk_pop, stk_clr;
    logic [DW-1:0] stk_q = '0;
    logic [DW-1:0] replay_code;
    logic          replay_valid, replay_done, busy, overflow;
    logic [2:0]    depth;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    spell_recorder #(.DATA_WIDTH(DW), .MAX_DEPTH(MD), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .btn(btn), .record_en(record_en),
        .replay_start(replay_start), .clear(clear), .stk_d(stk_d),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_clr(stk_clr),
        .stk_q(stk_q), .replay_code(replay_code), .replay_valid(replay_valid),
        .replay_done(replay_done), .busy(busy), .overflow(overflow), .depth(depth)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Downstream stack: read data appears the cycle after stk_pop.
    logic [DW-1:0] stack_m[$];
    always @(posedge clk) begin
        if (stk_clr) stack_m.delete();
        else if (stk_push) stack_m.push_back(stk_d);
        else if (stk_pop && stack_m.size() > 0) stk_q <= stack_m.pop_back();
    end

    // Reference model state
    bit            chk_on = 0;
    bit            rec_mode, rp_active, exp_ovf;
    int            rp_t0, rp_n, exp_depth;
    logic [DW-1:0] rp_list[$];
    logic [DW-1:0] moves[$];
    logic [DW-1:0] prev_code, btn_prev_m;

    task automatic model_reset();
        exp_depth = 0; exp_ovf = 0; moves.delete(); rp_list.delete();
        rp_active = 0; rec_mode = 0; prev_code = '0; btn_prev_m = '0;
    endtask

    always @(negedge clk) begin
        int r, k, j, kk;
        bit idle_m, evv, e_push, e_clr, e_pop, e_valid, e_done, nxt_rec;
        logic [DW-1:0] e_code;
        if (chk_on) begin
            idle_m  = !rec_mode && !rp_active;
            evv     = rec_mode && ($countones(btn & ~btn_prev_m) == 1);
            e_push  = evv && (exp_depth < MD);
            e_clr   = idle_m && clear;
            e_pop = 0; e_valid = 0; e_done = 0; e_code = prev_code;
            if (rp_active) begin
                r = cyc - rp_t0;
                if (rp_n == 0) begin
                    e_done = (r == 1);
                end else begin
                    k = (r - 1) / P;
                    j = (r - 1) % P;
                    e_pop   = (j == 0) && (k < rp_n);
                    e_valid = (j >= 2) && (k < rp_n);
                    e_done  = (r == 1 + rp_n * P);
                    if (r >= 3) begin
                        kk = (r - 3) / P;
                        if (kk > rp_n - 1) kk = rp_n - 1;
                        e_code = rp_list[rp_n - 1 - kk];
                    end
                end
            end
            chk("stk_push", stk_push, e_push);
            chk("stk_d", stk_d, e_push ? btn : '0);
            chk("stk_pop", stk_pop, e_pop);
            chk("stk_clr", stk_clr, e_clr);
            chk("replay_valid", replay_valid, e_valid);
            chk("replay_code", replay_code, e_code);
            chk("replay_done", replay_done, e_done);
            chk("busy", busy, !idle_m);
            chk("depth", depth, exp_depth);
            chk("overflow", overflow, exp_ovf);

            if (idle_m) nxt_rec = !clear && !replay_start && record_en;
            else if (rec_mode) nxt_rec = record_en;
            else nxt_rec = 0;
            if (e_push) begin
                moves.push_back(btn);
                exp_depth++;
            end
            if (evv && !e_push) exp_ovf = 1;
            if (e_pop) exp_depth--;
            if (rp_active && e_done) begin
                rp_active = 0;
                prev_code = e_code;
            end
            if (e_clr) begin
                exp_depth = 0; exp_ovf = 0; moves.delete();
            end else if (idle_m && replay_start) begin
                rp_active = 1; rp_t0 = cyc; rp_n = exp_depth;
                rp_list = moves; moves.delete();
            end
            rec_mode   = nxt_rec;
            btn_prev_m = btn;
        end
    end

    // Event capture for the literal checks
    logic [DW-1:0] push_log[$];
    logic [DW-1:0] code_log[$];
    int rise_cyc[$];
    int pop_n, clr_n, valid_n, done_cyc;
    bit done_seen, valid_prev;
    always @(negedge clk) begin
        if (stk_push) push_log.push_back(stk_d);
        if (stk_pop) pop_n++;
        if (stk_clr) clr_n++;
        if (replay_valid && !valid_prev) begin
            code_log.push_back(replay_code);
            rise_cyc.push_back(cyc);
        end
        if (replay_valid) valid_n++;
        valid_prev = replay_valid;
        if (replay_done) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
    end

    task automatic clear_logs();
        push_log.delete(); code_log.delete(); rise_cyc.delete();
        pop_n = 0; clr_n = 0; valid_n = 0; done_seen = 0; done_cyc = -1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [DW-1:0] v);
        btn = v; tick(2);
        btn = '0; tick(2);
    endtask

    task automatic do_reset();
        int n;
        chk_on = 0;
        reset = 1'b0; btn = '0; record_en = 0; replay_start = 0; clear = 0;
        tick(3);
        chk("reset_outputs_zero", {stk_d, stk_push, stk_pop, stk_clr, replay_code,
            replay_valid, replay_done, busy, overflow, depth}, 0);
        reset = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (stk_clr) n++;
        end
        chk("init_clr_pulses", n, 1);
        chk("init_busy", busy, 0);
        chk("init_depth", depth, 0);
        model_reset();
        @(posedge clk); #1;
        chk_on = 1;
    endtask

    task automatic replay_and_wait(output int s);
        replay_start = 1; s = cyc; tick(1);
        replay_start = 0;
        for (int i = 0; i < 100 && !done_seen; i++) tick(1);
        chk("replay_done_seen", done_seen, 1);
        tick(1);
    endtask

    initial begin
        int s;
        clear_logs();
        do_reset();

        // record 1, 4, 2
        clear_logs();
        record_en = 1; tick(2);
        press(4'b0001); press(4'b0100); press(4'b0010);
        record_en = 0; tick(2);
        chk("rec_push_count", push_log.size(), 3);
        if (push_log.size() == 3) begin
            chk("rec_d0", push_log[0], 1);
            chk("rec_d1", push_log[1], 4);
            chk("rec_d2", push_log[2], 2);
        end
        chk("rec_depth", depth, 3);

        // LIFO replay
        clear_logs();
        replay_and_wait(s);
        chk("rp_strobes", code_log.size(), 3);
        if (code_log.size() == 3) begin
            chk("rp_code0", code_log[0], 2);
            chk("rp_code1", code_log[1], 4);
            chk("rp_code2", code_log[2], 1);
            chk("rp_first_latency", rise_cyc[0] - s, 3);
        end
        chk("rp_valid_cycles", valid_n, 12);
        chk("rp_pops", pop_n, 3);
        chk("rp_done_latency", done_cyc - s, 19);
        chk("rp_depth_end", depth, 0);
        chk("rp_code_hold", replay_code, 1);

        // overflow, clear ignored while recording, then clear in idle
        clear_logs();
        record_en = 1; tick(2);
        press(4'b0001); press(4'b0010);
        clear = 1; tick(1); clear = 0; tick(1);
        press(4'b0100); press(4'b1000); press(4'b0001);
        record_en = 0; tick(2);
        chk("ovf_pushes", push_log.size(), 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_depth", depth, 4);
        chk("ovf_clr_in_record", clr_n, 0);
        clear = 1; tick(1); clear = 0; tick(1);
        chk("clear_pulses", clr_n, 1);
        chk("clear_ovf", overflow, 0);
        chk("clear_depth", depth, 0);

        // simultaneous buttons, held button across record entry
        clear_logs();
        record_en = 1; tick(2);
        btn = 4'b0011; tick(2); btn = '0; tick(2);
        record_en = 0; tick(2);
        btn = 4'b0001; tick(2);
        record_en = 1; tick(3);
        btn = '0; tick(1);
        record_en = 0; tick(2);
        chk("ignored_pushes", push_log.size(), 0);
        chk("ignored_depth", depth, 0);

        // replay of an empty stack
        clear_logs();
        replay_and_wait(s);
        chk("empty_done_latency", done_cyc - s, 1);
        chk("empty_pops", pop_n, 0);

        // reset during SHOW
        clear_logs();
        record_en = 1; tick(2);
        press(4'b1000); press(4'b0010);
        record_en = 0; tick(2);
        replay_start = 1; tick(1); replay_start = 0;
        for (int i = 0; i < 20 && !replay_valid; i++) tick(1);
        chk("show_reached", replay_valid, 1);
        @(negedge clk); #2;
        chk_on = 0;
        reset = 1'b0;
        #1;
        chk("abort_outputs_zero", {stk_d, stk_push, stk_pop, stk_clr, replay_code,
            replay_valid, replay_done, busy, overflow, depth}, 0);
        do_reset();
        tick(4);
        chk("post_abort_depth", depth, 0);

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
